// File: rtl/mul_acc_pkg.sv
// Shared types and helpers for the sequential multiply/accumulate engine.
package mul_acc_pkg;

  typedef enum logic [1:0] {
    MODE_MUL = 2'b00,
    MODE_MAC = 2'b01,
    MODE_ADD = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Iteration counter width; it only has to reach WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mul_acc_core.sv
// Shift-add multiplier datapath: one partial product per cycle, WIDTH cycles per product.
module mul_acc_core
  import mul_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  logic [PW-1:0]    a_shift_q, a_shift_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [PW-1:0]    p_step;
  logic             last;

  always_comb begin
    a_shift_d = a_shift_q;
    b_d       = b_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    p_step    = b_q[0] ? (p_q + a_shift_q) : p_q;
    last      = run_q && (cnt_q == CW'(WIDTH - 1));

    if (start_i) begin
      a_shift_d = PW'(a_i);
      b_d       = b_i;
      p_d       = '0;
      cnt_d     = '0;
      run_d     = 1'b1;
    end else if (run_q) begin
      p_d       = p_step;
      a_shift_d = a_shift_q << 1;
      b_d       = b_q >> 1;
      cnt_d     = last ? '0 : cnt_q + CW'(1);
      run_d     = !last;
    end
  end

  // The final partial sum is exposed combinationally so the owner can
  // capture it on the same edge as the last iteration.
  assign done_o    = last;
  assign product_o = p_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_shift_q <= '0;
      b_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
    end else begin
      a_shift_q <= a_shift_d;
      b_q       <= b_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
    end
  end

endmodule

// File: rtl/mul_acc_seq.sv
// Sequential multiply/accumulate engine: command FSM, handshakes, accumulator and sticky overflow.
module mul_acc_seq
  import mul_acc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2 * WIDTH + 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow,
  output logic                 busy
);

  localparam int AW1 = ACC_WIDTH + 1;

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]   result_q, result_d;
  logic                   core_start;
  logic                   core_done;
  logic [2*WIDTH-1:0]     core_product;
  logic [AW1-1:0]         acc_sum;
  logic [WIDTH:0]         add_sum;

  mul_acc_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start_i   (core_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (core_done),
    .product_o (core_product)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    core_start = 1'b0;
    // One extra bit keeps the accumulator carry-out for the sticky flag.
    acc_sum    = AW1'(acc_q) + AW1'(core_product);
    add_sum    = {1'b0, a} + {1'b0, b};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d = mode_e'(mode);
          case (mode_e'(mode))
            MODE_MUL, MODE_MAC: begin
              core_start = 1'b1;
              state_d    = ST_MUL;
            end
            MODE_ADD: begin
              result_d = ACC_WIDTH'(add_sum);
              state_d  = ST_DONE;
            end
            default: begin
              acc_d    = '0;
              ovf_d    = 1'b0;
              result_d = '0;
              state_d  = ST_DONE;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (core_done) begin
          if (mode_q == MODE_MAC) begin
            acc_d    = acc_sum[ACC_WIDTH-1:0];
            ovf_d    = ovf_q | acc_sum[ACC_WIDTH];
            result_d = acc_sum[ACC_WIDTH-1:0];
          end else begin
            result_d = ACC_WIDTH'(core_product);
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_MUL;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;
  assign overflow  = ovf_q;

endmodule
